// File: rtl/host_cfg_cmd_decoder.sv
// Host command byte-stream parser: decodes framed SYNC/ID/VALUE/CHK writes into
// one-cycle register strobes, flags frame errors and counts good/bad frames.
`timescale 1ns/1ps
module host_cfg_cmd_decoder #(
  parameter logic [7:0]  NBW_MIN        = 8'd1,
  parameter logic [7:0]  NBW_MAX        = 8'd200,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic        PCIE_dma_engine_clk,
  input  logic        rst,
  input  logic [7:0]  cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [7:0]  narrow_band_width,
  output logic        narrow_band_width_en,
  output logic [1:0]  filter_mode,
  output logic        filter_mode_en,
  output logic [7:0]  start_cmp_position,
  output logic        start_cmp_position_en,
  output logic        cmd_err,
  output logic [1:0]  cmd_err_code,
  output logic [15:0] frame_ok_cnt,
  output logic [15:0] frame_err_cnt
);

  typedef enum logic [2:0] {IDLE, GET_ID, GET_VAL, GET_CHK, APPLY} state_t;

  localparam logic [1:0] ERR_CHECKSUM = 2'd0;
  localparam logic [1:0] ERR_UNKNOWN  = 2'd1;
  localparam logic [1:0] ERR_RANGE    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  state_t      state_reg, state_next;
  logic [7:0]  reg_id_reg, reg_id_next;
  logic [7:0]  value_reg, value_next;
  logic [7:0]  chk_reg, chk_next;
  logic [15:0] gap_cnt_reg, gap_cnt_next;

  logic [7:0]  nbw_reg, nbw_next;
  logic        nbw_en_reg, nbw_en_next;
  logic [1:0]  fm_reg, fm_next;
  logic        fm_en_reg, fm_en_next;
  logic [7:0]  scp_reg, scp_next;
  logic        scp_en_reg, scp_en_next;
  logic        err_reg, err_next;
  logic [1:0]  err_code_reg, err_code_next;
  logic [15:0] frame_ok_cnt_reg, frame_ok_cnt_next;
  logic [15:0] frame_err_cnt_reg, frame_err_cnt_next;

  logic xfer;
  logic chk_good;
  logic id_known;
  logic in_range;

  assign cmd_ready = !rst && (state_reg != APPLY);
  assign xfer      = cmd_valid && cmd_ready;

  assign chk_good = (chk_reg == (reg_id_reg ^ value_reg ^ 8'h5A));
  assign id_known = (reg_id_reg == 8'h01) || (reg_id_reg == 8'h02) || (reg_id_reg == 8'h03);

  always_comb begin
    in_range = 1'b1;
    case (reg_id_reg)
      8'h01:   in_range = (value_reg >= NBW_MIN) && (value_reg <= NBW_MAX);
      8'h02:   in_range = (value_reg[7:2] == 6'd0);
      default: in_range = 1'b1;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    reg_id_next   = reg_id_reg;
    value_next    = value_reg;
    chk_next      = chk_reg;
    gap_cnt_next  = gap_cnt_reg;
    nbw_next      = nbw_reg;
    nbw_en_next   = 1'b0;
    fm_next       = fm_reg;
    fm_en_next    = 1'b0;
    scp_next      = scp_reg;
    scp_en_next   = 1'b0;
    err_next      = 1'b0;
    err_code_next = err_code_reg;

    case (state_reg)
      IDLE: begin
        if (xfer && (cmd_data == SYNC_BYTE)) begin
          state_next = GET_ID;
        end
      end
      GET_ID, GET_VAL, GET_CHK: begin
        if (xfer) begin
          gap_cnt_next = 16'd0;
          case (state_reg)
            GET_ID: begin
              reg_id_next = cmd_data;
              state_next  = GET_VAL;
            end
            GET_VAL: begin
              value_next = cmd_data;
              state_next = GET_CHK;
            end
            default: begin
              chk_next   = cmd_data;
              state_next = APPLY;
            end
          endcase
        end else if (gap_cnt_reg == TIMEOUT_CYCLES) begin
          // A byte landing on the limit cycle wins; only a silent limit cycle aborts.
          state_next    = IDLE;
          err_next      = 1'b1;
          err_code_next = ERR_TIMEOUT;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      APPLY: begin
        state_next = IDLE;
        if (!chk_good) begin
          err_next      = 1'b1;
          err_code_next = ERR_CHECKSUM;
        end else if (!id_known) begin
          err_next      = 1'b1;
          err_code_next = ERR_UNKNOWN;
        end else if (!in_range) begin
          err_next      = 1'b1;
          err_code_next = ERR_RANGE;
        end else begin
          case (reg_id_reg)
            8'h01: begin
              nbw_next    = value_reg;
              nbw_en_next = 1'b1;
            end
            8'h02: begin
              fm_next    = value_reg[1:0];
              fm_en_next = 1'b1;
            end
            default: begin
              scp_next    = value_reg;
              scp_en_next = 1'b1;
            end
          endcase
        end
      end
      default: state_next = IDLE;
    endcase

    if (state_next == IDLE) begin
      gap_cnt_next = 16'd0;
    end
  end

  always_comb begin
    frame_ok_cnt_next  = frame_ok_cnt_reg;
    frame_err_cnt_next = frame_err_cnt_reg;
    if ((nbw_en_next || fm_en_next || scp_en_next) && (frame_ok_cnt_reg != 16'hFFFF)) begin
      frame_ok_cnt_next = frame_ok_cnt_reg + 16'd1;
    end
    if (err_next && (frame_err_cnt_reg != 16'hFFFF)) begin
      frame_err_cnt_next = frame_err_cnt_reg + 16'd1;
    end
  end

  always_ff @(posedge PCIE_dma_engine_clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      reg_id_reg        <= 8'd0;
      value_reg         <= 8'd0;
      chk_reg           <= 8'd0;
      gap_cnt_reg       <= 16'd0;
      nbw_reg           <= 8'd0;
      nbw_en_reg        <= 1'b0;
      fm_reg            <= 2'd0;
      fm_en_reg         <= 1'b0;
      scp_reg           <= 8'd0;
      scp_en_reg        <= 1'b0;
      err_reg           <= 1'b0;
      err_code_reg      <= 2'd0;
      frame_ok_cnt_reg  <= 16'd0;
      frame_err_cnt_reg <= 16'd0;
    end else begin
      state_reg         <= state_next;
      reg_id_reg        <= reg_id_next;
      value_reg         <= value_next;
      chk_reg           <= chk_next;
      gap_cnt_reg       <= gap_cnt_next;
      nbw_reg           <= nbw_next;
      nbw_en_reg        <= nbw_en_next;
      fm_reg            <= fm_next;
      fm_en_reg         <= fm_en_next;
      scp_reg           <= scp_next;
      scp_en_reg        <= scp_en_next;
      err_reg           <= err_next;
      err_code_reg      <= err_code_next;
      frame_ok_cnt_reg  <= frame_ok_cnt_next;
      frame_err_cnt_reg <= frame_err_cnt_next;
    end
  end

  assign narrow_band_width     = nbw_reg;
  assign narrow_band_width_en  = nbw_en_reg;
  assign filter_mode           = fm_reg;
  assign filter_mode_en        = fm_en_reg;
  assign start_cmp_position    = scp_reg;
  assign start_cmp_position_en = scp_en_reg;
  assign cmd_err               = err_reg;
  assign cmd_err_code          = err_code_reg;
  assign frame_ok_cnt          = frame_ok_cnt_reg;
  assign frame_err_cnt         = frame_err_cnt_reg;

endmodule

// File: tb/tb_host_cfg_cmd_decoder.sv
// Bench for host_cfg_cmd_decoder: directed and random frames checked against a
// frame-level model of the decode rules, timeout, reset and saturation behaviour.
`timescale 1ns/1ps
module tb_host_cfg_cmd_decoder;

  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  narrow_band_width;
  logic        narrow_band_width_en;
  logic [1:0]  filter_mode;
  logic        filter_mode_en;
  logic [7:0]  start_cmp_position;
  logic        start_cmp_position_en;
  logic        cmd_err;
  logic [1:0]  cmd_err_code;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  always #5 clk = ~clk;

  host_cfg_cmd_decoder dut (
    .PCIE_dma_engine_clk   (clk),
    .rst                   (rst),
    .cmd_data              (cmd_data),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .narrow_band_width     (narrow_band_width),
    .narrow_band_width_en  (narrow_band_width_en),
    .filter_mode           (filter_mode),
    .filter_mode_en        (filter_mode_en),
    .start_cmp_position    (start_cmp_position),
    .start_cmp_position_en (start_cmp_position_en),
    .cmd_err               (cmd_err),
    .cmd_err_code          (cmd_err_code),
    .frame_ok_cnt          (frame_ok_cnt),
    .frame_err_cnt         (frame_err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected register-file view
  logic [7:0] m_nbw  = 8'd0;
  logic [1:0] m_fm   = 2'd0;
  logic [7:0] m_scp  = 8'd0;
  logic [1:0] m_code = 2'd0;
  int         m_ok   = 0;
  int         m_err  = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, ".nbw_en"}, 16'(narrow_band_width_en), 16'd0);
    chk({tag, ".fm_en"}, 16'(filter_mode_en), 16'd0);
    chk({tag, ".scp_en"}, 16'(start_cmp_position_en), 16'd0);
    chk({tag, ".err"}, 16'(cmd_err), 16'd0);
    chk({tag, ".code"}, 16'(cmd_err_code), 16'(m_code));
    chk({tag, ".nbw"}, 16'(narrow_band_width), 16'(m_nbw));
    chk({tag, ".fm"}, 16'(filter_mode), 16'(m_fm));
    chk({tag, ".scp"}, 16'(start_cmp_position), 16'(m_scp));
    chk({tag, ".ok_cnt"}, frame_ok_cnt, 16'(m_ok));
    chk({tag, ".err_cnt"}, frame_err_cnt, 16'(m_err));
  endtask

  // Called and returns at posedge+1; the byte transfers on the next accepted edge.
  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    cmd_data  = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && guard < 4) begin
      guard++;
      @(posedge clk); #1;
    end
    chk("ready_wait", 16'(cmd_ready), 16'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'($urandom);
  endtask

  task automatic idle_gap(input int maxgap);
    repeat ($urandom_range(0, maxgap)) begin
      @(posedge clk); #1;
    end
  endtask

  // Frame rules: checksum first, then register ID, then value range.
  task automatic model_frame(input logic [7:0] id, input logic [7:0] val, input logic [7:0] c,
                             output bit is_err, output logic [1:0] code);
    is_err = 1'b1;
    code   = 2'd0;
    if (c != (id ^ val ^ 8'h5A))            code = 2'd0;
    else if (id < 8'd1 || id > 8'd3)        code = 2'd1;
    else if (id == 8'd1 && (val < 8'd1 || val > 8'd200)) code = 2'd2;
    else if (id == 8'd2 && val > 8'd3)      code = 2'd2;
    else                                    is_err = 1'b0;
  endtask

  task automatic finish_frame(input logic [7:0] id, input logic [7:0] val, input logic [7:0] c);
    bit         e;
    logic [1:0] code;
    model_frame(id, val, c, e, code);
    @(negedge clk);
    chk("apply.ready", 16'(cmd_ready), 16'd0);
    check_quiet("apply");
    @(negedge clk);
    chk("res.ready", 16'(cmd_ready), 16'd1);
    if (e) begin
      m_code = code;
      chk("res.err", 16'(cmd_err), 16'd1);
      chk("res.code", 16'(cmd_err_code), 16'(m_code));
      chk("res.nbw_en", 16'(narrow_band_width_en), 16'd0);
      chk("res.fm_en", 16'(filter_mode_en), 16'd0);
      chk("res.scp_en", 16'(start_cmp_position_en), 16'd0);
      if (m_err < 65535) m_err++;
    end else begin
      if (id == 8'd1) m_nbw = val;
      if (id == 8'd2) m_fm = val[1:0];
      if (id == 8'd3) m_scp = val;
      chk("res.err", 16'(cmd_err), 16'd0);
      chk("res.nbw_en", 16'(narrow_band_width_en), 16'(id == 8'd1));
      chk("res.fm_en", 16'(filter_mode_en), 16'(id == 8'd2));
      chk("res.scp_en", 16'(start_cmp_position_en), 16'(id == 8'd3));
      if (m_ok < 65535) m_ok++;
    end
    chk("res.nbw", 16'(narrow_band_width), 16'(m_nbw));
    chk("res.fm", 16'(filter_mode), 16'(m_fm));
    chk("res.scp", 16'(start_cmp_position), 16'(m_scp));
    $display("frame id=%h val=%h chk=%h -> %s code=%0d ok_cnt=%0d err_cnt=%0d",
             id, val, c, e ? "error" : "write", code, m_ok, m_err);
    @(negedge clk);
    check_quiet("post");
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input logic [7:0] id, input logic [7:0] val, input logic [7:0] c,
                           input int maxgap);
    send_byte(8'hA5);
    idle_gap(maxgap);
    send_byte(id);
    idle_gap(maxgap);
    send_byte(val);
    idle_gap(maxgap);
    send_byte(c);
    finish_frame(id, val, c);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b, id, val, c;
    int sel, nn;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.ready", 16'(cmd_ready), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset.ready_after", 16'(cmd_ready), 16'd1);
    check_quiet("reset");
    @(posedge clk); #1;

    // Directed frames
    run_frame(8'h01, 8'h19, 8'h42, 0);
    run_frame(8'h02, 8'h01, 8'h59, 0);
    run_frame(8'h02, 8'h05, 8'h5D, 0);
    run_frame(8'h03, 8'h80, 8'hD8, 0);
    run_frame(8'h07, 8'h00, 8'h5D, 0);
    run_frame(8'h09, 8'h00, 8'h00, 1);
    run_frame(8'hA5, 8'h00, 8'hFF, 1);
    run_frame(8'h01, 8'h00, 8'h5B, 1);
    run_frame(8'h01, 8'hC8, 8'h93, 1);
    run_frame(8'h01, 8'hC9, 8'h92, 1);
    run_frame(8'h01, 8'h01, 8'h5A, 1);

    // Noise in IDLE is dropped silently
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    @(negedge clk);
    check_quiet("noise");
    @(posedge clk); #1;
    run_frame(8'h03, 8'h10, 8'h49, 0);

    // Silent limit cycle aborts the frame
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TIMEOUT) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_quiet("to.limit");
    @(negedge clk);
    m_code = 2'd3;
    if (m_err < 65535) m_err++;
    chk("to.err", 16'(cmd_err), 16'd1);
    chk("to.code", 16'(cmd_err_code), 16'(m_code));
    chk("to.err_cnt", frame_err_cnt, 16'(m_err));
    chk("to.ok_cnt", frame_ok_cnt, 16'(m_ok));
    $display("timeout frame -> error code=3 err_cnt=%0d", m_err);
    @(negedge clk);
    check_quiet("to.post");
    @(posedge clk); #1;
    run_frame(8'h03, 8'h22, 8'h7B, 0);

    // Byte arriving on the limit cycle is accepted
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TIMEOUT) begin
      @(posedge clk); #1;
    end
    send_byte(8'h19);
    send_byte(8'h42);
    finish_frame(8'h01, 8'h19, 8'h42);

    // Randomized frames
    for (int i = 0; i < 40; i++) begin
      nn = $urandom_range(0, 2);
      for (int k = 0; k < nn; k++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_byte(b);
      end
      sel = $urandom_range(0, 4);
      id  = (sel < 3) ? 8'(sel + 1) : 8'($urandom);
      val = 8'($urandom);
      if (sel == 1 && $urandom_range(0, 1) == 1) val = val & 8'h03;
      c = id ^ val ^ 8'h5A;
      if ($urandom_range(0, 4) == 0) c = c ^ 8'(1 << $urandom_range(0, 7));
      run_frame(id, val, c, 3);
    end

    // Reset in the middle of a frame
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h19);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.ready", 16'(cmd_ready), 16'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    m_nbw  = 8'd0;
    m_fm   = 2'd0;
    m_scp  = 8'd0;
    m_code = 2'd0;
    m_ok   = 0;
    m_err  = 0;
    @(negedge clk);
    chk("midrst.ready_after", 16'(cmd_ready), 16'd1);
    check_quiet("midrst");
    @(posedge clk); #1;
    send_byte(8'h42);
    @(negedge clk);
    check_quiet("midrst.drop0");
    @(negedge clk);
    check_quiet("midrst.drop1");
    @(posedge clk); #1;
    $display("reset mid-frame -> frame discarded, counters cleared");

    // Good-frame counter saturation
    force dut.frame_ok_cnt_reg = 16'hFFFE;
    @(negedge clk);
    release dut.frame_ok_cnt_reg;
    m_ok = 65534;
    chk("sat.pre", frame_ok_cnt, 16'(m_ok));
    @(posedge clk); #1;
    run_frame(8'h03, 8'h55, 8'h0C, 0);
    run_frame(8'h03, 8'h56, 8'h0F, 0);
    chk("sat.final", frame_ok_cnt, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
